// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings and the flag bundle shared by the ALU control
// decoder and the execute stage, so the encodings live in one place.
package alu_pkg;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_BITS-1:0] OP_ORR   = 4'b0001;
  localparam logic [OP_BITS-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_EOR   = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_PASSB = 4'b0111;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// alu_core: purely combinational ALU datapath.
//   operation : ALU operation code
//   a, b      : operands
//   result    : ALU result
//   flags     : zero / negative / overflow / carry / illegal
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 4
) (
  input  logic [OPW-1:0]   operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // SUB is A + ~B + 1 so carry is the inverted borrow.
  assign sub   = (operation == OP_SUB);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    result = '0;
    flags  = '0;
    // Unknown or X codes fall through to default and are reported as illegal.
    case (operation)
      OP_AND:   result = a & b;
      OP_ORR:   result = a | b;
      OP_EOR:   result = a ^ b;
      OP_PASSB: result = b;
      OP_ADD, OP_SUB: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default:  flags.illegal = 1'b1;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage registered execute stage.
//   S1 registers operation/a/b on the input handshake; S2 registers the
//   alu_core result and flags. All outputs come straight from S2 flops.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   operation, a, b     : operation code and operands
//   out_valid/out_ready : downstream handshake
//   result, zero, negative, overflow, carry, illegal : registered outputs
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             illegal
);

  logic             s1_valid;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  logic [WIDTH-1:0] s2_result;
  alu_flags_t       s2_flags;
  logic             s2_valid;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= operation;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .operation (s1_op),
    .a         (s1_a),
    .b         (s1_b),
    .result    (core_result),
    .flags     (core_flags)
  );

  // A bubble from S1 only clears the valid bit; the data flops keep their
  // last value, which is harmless because out_valid qualifies them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_flags  <= core_flags;
      end
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign zero      = s2_flags.zero;
  assign negative  = s2_flags.negative;
  assign overflow  = s2_flags.overflow;
  assign carry     = s2_flags.carry;
  assign illegal   = s2_flags.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table streamed back-to-back, plus
// hand-written backpressure and asynchronous-reset sequences.
module tb_alu_exec_stage;

  localparam int unsigned W = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    operation;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          negative;
  logic          overflow;
  logic          carry;
  logic          illegal;

  int n_cmp;
  int n_bad;

  alu_exec_stage #(
    .WIDTH (W),
    .OPW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .carry     (carry),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {zero, negative, overflow, carry, illegal}
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   fl;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {zero, negative, overflow, carry, illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv);
    in_valid  = v;
    operation = op;
    a         = av;
    b         = bv;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //           op       a                      b                      result                 {z,n,v,c,i}
    vecs[0]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                64'h8000_0000_0000_0000, 5'b01100};
    vecs[1]  = '{4'b0110, 64'd5,                 64'd5,                  64'd0,                   5'b10010};
    vecs[2]  = '{4'b0110, 64'd0,                 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 5'b01000};
    vecs[3]  = '{4'b0000, 64'hF0F0,              64'hFF00,               64'hF000,                5'b00000};
    vecs[4]  = '{4'b0001, 64'h0F,                64'hF0,                 64'hFF,                  5'b00000};
    vecs[5]  = '{4'b0101, 64'hFF,                64'h0F,                 64'hF0,                  5'b00000};
    vecs[6]  = '{4'b0111, 64'h1234,              64'd0,                  64'd0,                   5'b10000};
    vecs[7]  = '{4'b1111, 64'd3,                 64'd4,                  64'd0,                   5'b10001};
    vecs[8]  = '{4'b0010, 64'd2,                 64'd3,                  64'd5,                   5'b00000};
    vecs[9]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                64'd0,                   5'b10010};
    vecs[10] = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1,                64'h7FFF_FFFF_FFFF_FFFF, 5'b00110};
    vecs[11] = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               5'b10001};
    vecs[12] = '{4'b0010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0,               5'b10110};

    // Reset
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, '0, '0);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", {59'd0, dut_flags()}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

    // Stream the table back-to-back; S2 holds vector i-1 after accepting vector i.
    for (int i = 0; i <= NV + 1; i++) begin
      if (i < NV) begin
        drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
        chk($sformatf("stream_in_ready[%0d]", i), {63'd0, in_ready}, 64'd1);
      end else begin
        drive(1'b0, 4'd0, '0, '0);
      end
      tick();
      if (i >= 1 && i <= NV) begin
        chk($sformatf("stream_valid[%0d]", i-1), {63'd0, out_valid}, 64'd1);
        chk($sformatf("stream_result[%0d]", i-1), result, vecs[i-1].res);
        chk($sformatf("stream_flags[%0d]", i-1), {59'd0, dut_flags()}, {59'd0, vecs[i-1].fl});
      end else if (i == NV + 1) begin
        chk("stream_drained", {63'd0, out_valid}, 64'd0);
      end else begin
        chk("stream_latency_first", {63'd0, out_valid}, 64'd0);
      end
    end

    // Backpressure: A=10+1, B=20+2, C=EOR 0xFF^0x01
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 64'd10, 64'd1);
    chk("bp_ready_c0", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b1, 4'b0010, 64'd20, 64'd2);
    chk("bp_ready_c1", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_first_result", result, 64'd11);
    drive(1'b1, 4'b0101, 64'hFF, 64'h01);
    chk("bp_ready_full", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_hold1_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_hold1_result", result, 64'd11);
    chk("bp_ready_full2", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_hold2_result", result, 64'd11);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("bp_second_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_second_result", result, 64'd22);
    tick();
    chk("bp_third_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_third_result", result, 64'hFE);
    tick();
    chk("bp_end_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with S1 and S2 both occupied
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    drive(1'b1, 4'b0010, 64'd1, 64'd1);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("ar_pre_flags", {59'd0, dut_flags()}, {59'd0, 5'b01100});
    chk("ar_pre_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("ar_result_drop", result, 64'd0);
    chk("ar_flags_drop", {59'd0, dut_flags()}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ar_no_stale[%0d]", k), {63'd0, out_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered 64-bit execute stage downstream of the ALU control decoder.
- Consumes the 4-bit Operation code plus two 64-bit operands and produces result and condition flags: Zero for CBZ, and N/V/C for flag-setting ops.
- Two-stage pipeline (operand register, then result register) with valid/ready handshakes on both sides.
- Sits between register-read/immediate-select and the memory/writeback stage.

Parameters:
- WIDTH, 64, operand/result width in bits.
- OPW, 4, width of the Operation code.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage accepts input this cycle.
- operation  input  OPW  ALU operation code.
- a  input  WIDTH  operand A (register Rn).
- b  input  WIDTH  operand B (Rm or immediate).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  ALU result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (add/sub only, else 0).
- carry  output  1  carry out (add), NOT borrow (sub), else 0.
- illegal  output  1  operation code not in the supported set.

Behaviour:
- Reset is asynchronous and active-high, with one clock: clk, rst. While rst is high:
  - out_valid=0, result=0, and all flags=0;
  - stage-1 valid=0;
  - in_ready=1 from the first cycle after rst deasserts.
- Operation encodings:
  - 0000 AND: A&B.
  - 0001 ORR: A|B.
  - 0010 ADD: A+B.
  - 0110 SUB: A-B, computed as A+~B+1.
  - 0101 EOR: A^B.
  - 0111 PASSB: B (CBZ test).
  - Any other code: result=0, illegal=1, flags=0 except zero=1.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum; carry = bit WIDTH.
  - overflow = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B for ADD and ~B for SUB.
  - Logic ops and PASSB: overflow=0, carry=0.
- Pipeline:
  - Stage 1 (S1) latches a, b and operation on in_valid && in_ready.
  - Stage 2 (S2) latches the computed result and flags from S1 when S1 is valid and S2 is empty or draining.
  - Latency is 2 cycles from input handshake to out_valid, assuming no stall.
  - Throughput is 1 op/cycle while out_ready=1.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, registered-free combinational from state and out_ready.
  - While out_valid=1 && out_ready=0, result and flags hold stable. No input is lost; S1 holds its op.
  - A bubble in S1 (s1_valid=0) with s2_adv clears out_valid on the next edge.
- Simultaneous events: an accept into S1, a move from S1 to S2, and an output handshake can all occur in the same cycle.
- Outputs: all are registered and driven only from S2 flops.
- Reset mid-operation: in-flight ops in S1/S2 are discarded and outputs return to reset values immediately (asynchronous).
- No X propagation: an unknown operation code is treated as illegal.

Decomposition:
- Shared package alu_pkg:
  - localparam constants OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_EOR, OP_PASSB;
  - a flags struct {zero, negative, overflow, carry, illegal}.
- The package is also imported by the ALU control decoder so the encodings stay single-sourced.
- One combinational sub-module, alu_core, computes result and flags from (operation, a, b). The pipeline registers and handshake logic stay in alu_exec_stage.

Test Plan:
- Reset then ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> out_valid after 2 cycles; result=0x8000_0000_0000_0000, negative=1, overflow=1, carry=0, zero=0.
- SUB a=5, b=5 -> result=0, zero=1, carry=1, overflow=0. Then SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, negative=1, carry=0.
- Back-to-back AND (0xF0F0, 0xFF00), ORR (0x0F, 0xF0), EOR (0xFF, 0x0F), PASSB (x, 0) with out_ready=1 -> four consecutive out_valid cycles with results 0xF000, 0xFF, 0xF0, 0 (zero=1); in_ready stays 1.
- Backpressure: hold out_ready=0 for 3 cycles while issuing 3 ops:
  - in_ready drops after S1 fills;
  - the first result is held stable;
  - after out_ready=1, results emerge in order with no drops or duplicates.
- Operation=1111 with a=3, b=4 -> illegal=1, result=0, zero=1; the following valid ADD clears illegal.
- Assert rst asynchronously while out_valid=1 and S1 is full -> out_valid and flags drop without a clock edge. After release, no stale result appears.
